// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states,
// and the default datapath width.
package mdu_pkg;

    localparam int MDU_DATA_W = 32;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mduOp_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mduState_e;

    // Multi-cycle ops are the ones that stall EX when issued.
    function automatic logic isLongOp(input logic [2:0] op);
        return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Restoring divider core: one shift/subtract/compare step per cycle on
// unsigned magnitudes; the caller owns step count and sign fix-up.
module mdu_div_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quot,
    output logic [DATA_W-1:0] rem
);

    logic [DATA_W-1:0] quotQ, remQ, divQ;
    logic [DATA_W:0]   remSh, diff;

    // remQ < divQ always holds, so DATA_W+1 bits cannot wrap the trial subtract.
    assign remSh = {remQ, quotQ[DATA_W-1]};
    assign diff  = remSh - {1'b0, divQ};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quotQ <= '0;
            remQ  <= '0;
            divQ  <= '0;
        end else if (load) begin
            quotQ <= dividend;
            remQ  <= '0;
            divQ  <= divisor;
        end else if (step) begin
            remQ  <= diff[DATA_W] ? remSh[DATA_W-1:0] : diff[DATA_W-1:0];
            quotQ <= {quotQ[DATA_W-2:0], ~diff[DATA_W]};
        end
    end

    assign quot = quotQ;
    assign rem  = remQ;

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer: runs MULT/DIV over several cycles,
// owns HI/LO, and drives ready_e for the hazard unit.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int DATA_W  = MDU_DATA_W,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              op_valid_e,
    input  logic [2:0]        op_e,
    input  logic [DATA_W-1:0] src_a_e,
    input  logic [DATA_W-1:0] src_b_e,
    input  logic              flush,
    output logic              ready_e,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2((DATA_W > MUL_LAT) ? DATA_W : MUL_LAT);

    mduState_e           state, nextState;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   hiQ, loQ, hiNext, loNext;
    logic                hiWe, loWe, readyE;
    logic                mulStart, divStart, divStep;
    logic                isSigned, signQ, signR;
    logic [DATA_W:0]     mulA, mulB;
    logic [2*DATA_W-1:0] mulAx, mulBx, prod;
    logic [DATA_W-1:0]   divA, divB, quot, rem;

    assign isSigned = (op_e == MDU_MULT) || (op_e == MDU_DIV);
    assign divA     = (isSigned && src_a_e[DATA_W-1]) ? -src_a_e : src_a_e;
    assign divB     = (isSigned && src_b_e[DATA_W-1]) ? -src_b_e : src_b_e;

    // 33-bit extended operands widened to 64; low 64 bits of the product are exact.
    assign mulAx = {{(DATA_W-1){mulA[DATA_W]}}, mulA};
    assign mulBx = {{(DATA_W-1){mulB[DATA_W]}}, mulB};
    assign prod  = mulAx * mulBx;

    mdu_div_iter #(.DATA_W(DATA_W)) uDiv (
        .clk      (clk),
        .resetn   (resetn),
        .load     (divStart),
        .step     (divStep),
        .dividend (divA),
        .divisor  (divB),
        .quot     (quot),
        .rem      (rem)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        readyE    = 1'b1;
        mulStart  = 1'b0;
        divStart  = 1'b0;
        divStep   = 1'b0;
        hiWe      = 1'b0;
        loWe      = 1'b0;
        hiNext    = hiQ;
        loNext    = loQ;
        unique case (state)
            ST_IDLE: if (op_valid_e) begin
                readyE = !isLongOp(op_e);
                case (op_e)
                    MDU_MULT, MDU_MULTU: begin
                        mulStart  = 1'b1;
                        nextState = ST_MUL;
                    end
                    MDU_DIV, MDU_DIVU: begin
                        if (src_b_e == '0) begin
                            hiWe      = 1'b1;
                            loWe      = 1'b1;
                            hiNext    = src_a_e;
                            loNext    = '1;
                            nextState = ST_DONE;
                        end else begin
                            divStart  = 1'b1;
                            nextState = ST_DIV;
                        end
                    end
                    MDU_MTHI: begin
                        hiWe   = 1'b1;
                        hiNext = src_a_e;
                    end
                    MDU_MTLO: begin
                        loWe   = 1'b1;
                        loNext = src_a_e;
                    end
                    default: ;
                endcase
            end
            ST_MUL: begin
                readyE = 1'b0;
                if (cnt == '0) begin
                    hiWe             = 1'b1;
                    loWe             = 1'b1;
                    {hiNext, loNext} = prod;
                    nextState        = ST_DONE;
                end
            end
            ST_DIV: begin
                readyE  = 1'b0;
                divStep = 1'b1;
                if (cnt == '0) nextState = ST_FIX;
            end
            ST_FIX: begin
                readyE    = 1'b0;
                hiWe      = 1'b1;
                loWe      = 1'b1;
                hiNext    = signR ? -rem : rem;
                loNext    = signQ ? -quot : quot;
                nextState = ST_DONE;
            end
            ST_DONE: nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
        // Exception flush wins over everything: no writes, no new op.
        if (flush) begin
            nextState = ST_IDLE;
            readyE    = 1'b1;
            mulStart  = 1'b0;
            divStart  = 1'b0;
            divStep   = 1'b0;
            hiWe      = 1'b0;
            loWe      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hiQ   <= '0;
            loQ   <= '0;
            cnt   <= '0;
            mulA  <= '0;
            mulB  <= '0;
            signQ <= 1'b0;
            signR <= 1'b0;
        end else begin
            if (hiWe) hiQ <= hiNext;
            if (loWe) loQ <= loNext;
            if (mulStart) begin
                mulA <= {isSigned & src_a_e[DATA_W-1], src_a_e};
                mulB <= {isSigned & src_b_e[DATA_W-1], src_b_e};
                cnt  <= CNT_W'(MUL_LAT - 1);
            end else if (divStart) begin
                signQ <= isSigned & (src_a_e[DATA_W-1] ^ src_b_e[DATA_W-1]);
                signR <= isSigned & src_a_e[DATA_W-1];
                cnt   <= CNT_W'(DATA_W - 1);
            end else if ((state == ST_MUL || state == ST_DIV) && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign ready_e = readyE;
    assign hi_o    = hiQ;
    assign lo_o    = loQ;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: the driver queues expected latency/HI/LO per op,
// a negedge monitor pops and compares when EX sees the op accepted.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        opValid = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = MDU_NOP;
    logic [31:0] srcA = '0, srcB = '0;
    logic        readyE;
    logic [31:0] hi, lo;

    typedef struct {
        string       nm;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.DATA_W(32), .MUL_LAT(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .op_valid_e (opValid),
        .op_e       (op),
        .src_a_e    (srcA),
        .src_b_e    (srcB),
        .flush      (flush),
        .ready_e    (readyE),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: counts ready_e-low cycles of the held op, checks HI/LO after acceptance.
    initial begin : monitor
        int   lowCnt;
        int   pendLat;
        bit   pend;
        exp_t e;
        lowCnt  = 0;
        pendLat = 0;
        pend    = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                pend = 0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion lat=%0d expected none", pendLat);
                end else begin
                    e = sb.pop_front();
                    check({e.nm, "_lat"}, 32'(pendLat), 32'(e.lat));
                    check({e.nm, "_hi"}, hi, e.hi);
                    check({e.nm, "_lo"}, lo, e.lo);
                end
            end
            if (!resetn || flush) lowCnt = 0;
            else if (opValid) begin
                if (!readyE) lowCnt++;
                else begin
                    pendLat = lowCnt;
                    lowCnt  = 0;
                    pend    = 1;
                end
            end
        end
    end

    // Present an op and hold it until accepted; leaves op_valid asserted.
    task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] eh,
                         input logic [31:0] el);
        exp_t e;
        int   n;
        e.nm = nm; e.lat = lat; e.hi = eh; e.lo = el;
        sb.push_back(e);
        opValid = 1'b1; op = o; srcA = a; srcB = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!readyE && n < 100);
        if (!readyE) begin
            errors++;
            $display("FAIL %s_timeout ready_e=%b expected 1 within 100 cycles", nm, readyE);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        opValid = 1'b0;
        op      = MDU_NOP;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin : main
        #1 resetn = 1'b0;
        #2;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_ready", 32'(readyE), 32'd1);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        issue("mult_neg", MDU_MULT,  32'hFFFF_FFFE, 32'd3,        3,  32'hFFFF_FFFF, 32'hFFFF_FFFA); idle(1);
        issue("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFE, 32'h0000_0001); idle(1);
        issue("divu_100_7", MDU_DIVU, 32'd100,       32'd7,        34, 32'd2,         32'd14);        idle(1);
        issue("div_m7_2",  MDU_DIV,   32'hFFFF_FFF9, 32'd2,        34, 32'hFFFF_FFFF, 32'hFFFF_FFFD); idle(1);
        issue("div_m8_m3", MDU_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 34, 32'hFFFF_FFFE, 32'd2);        idle(1);
        issue("divu_big",  MDU_DIVU,  32'hFFFF_FFFF, 32'd10,       34, 32'd5,         32'h1999_9999); idle(1);
        issue("div_by0",   MDU_DIV,   32'd5,         32'd0,        1,  32'd5,         32'hFFFF_FFFF); idle(1);
        issue("div_ovf",   MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0,        32'h8000_0000); idle(1);
        issue("mtlo",      MDU_MTLO,  32'h0000_5555, 32'd0,        0,  32'h0,         32'h0000_5555); idle(1);
        issue("mthi",      MDU_MTHI,  32'h0000_1111, 32'd0,        0,  32'h0000_1111, 32'h0000_5555); idle(1);

        // DIVU aborted by flush partway through the iterations.
        opValid = 1'b1; op = MDU_DIVU; srcA = 32'd1000; srcB = 32'd3;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("div_busy_ready", 32'(readyE), 32'd0);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        check("flush_ready", 32'(readyE), 32'd1);
        @(posedge clk); #1 flush = 1'b0; opValid = 1'b0; op = MDU_NOP;
        @(negedge clk);
        check("post_flush_ready", 32'(readyE), 32'd1);
        check("post_flush_hi", hi, 32'h0000_1111);
        check("post_flush_lo", lo, 32'h0000_5555);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("flush_late_hi", hi, 32'h0000_1111);
        check("flush_late_lo", lo, 32'h0000_5555);
        @(posedge clk); #1;

        // MTLO coincident with flush must not write.
        opValid = 1'b1; op = MDU_MTLO; srcA = 32'h0000_1234; flush = 1'b1;
        @(negedge clk);
        check("mtlo_flush_ready", 32'(readyE), 32'd1);
        @(posedge clk); #1 opValid = 1'b0; op = MDU_NOP; flush = 1'b0;
        @(negedge clk);
        check("mtlo_flush_lo", lo, 32'h0000_5555);
        @(posedge clk); #1;

        // Back-to-back: MTHI presented the cycle after MULT finishes.
        issue("mult_b2b", MDU_MULT, 32'd7,         32'd6, 3, 32'h0,         32'd42);
        issue("mthi_b2b", MDU_MTHI, 32'hA5A5_A5A5, 32'd0, 0, 32'hA5A5_A5A5, 32'd42);
        idle(2);

        // Reset asserted in the middle of a divide.
        opValid = 1'b1; op = MDU_DIV; srcA = 32'd100; srcB = 32'd7;
        repeat (6) @(posedge clk);
        #1 resetn = 1'b0; opValid = 1'b0; op = MDU_NOP;
        #1;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_ready", 32'(readyE), 32'd1);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        idle(1);

        issue("multu_post_rst", MDU_MULTU, 32'd3, 32'd5, 3, 32'h0, 32'd15);
        idle(3);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
